// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, constants and FIPS 180-4 helper functions.
package sha256_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned HASH_N   = 8;
  localparam int unsigned BLOCK_N  = 16;
  localparam int unsigned ROUNDS   = 64;
  localparam int unsigned ROUND_W  = 6;

  typedef logic [WORD_W-1:0]              word_t;
  typedef logic [0:HASH_N-1][WORD_W-1:0]  hash_t;
  typedef logic [0:BLOCK_N-1][WORD_W-1:0] block_t;

  localparam hash_t H0 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [0:ROUNDS-1][WORD_W-1:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_compress_iter_round.sv
// One combinational SHA-256 compression round: a..h, K[t], W[t] -> next a..h.
module sha256_compress_iter_round
  import sha256_pkg::*;
(
  input  hash_t cur,
  input  word_t kt,
  input  word_t wt,
  output hash_t next_c
);

  word_t t1;
  word_t t2;

  always_comb begin
    t1 = cur[7] + big_sigma1(cur[4]) + ch(cur[4], cur[5], cur[6]) + kt + wt;
    t2 = big_sigma0(cur[0]) + maj(cur[0], cur[1], cur[2]);
    next_c = {t1 + t2, cur[0], cur[1], cur[2], cur[3] + t1, cur[4], cur[5], cur[6]};
  end

endmodule

// File: rtl/sha256_compress_iter.sv
// Iterative single-shot SHA-256 compression: LOAD, 64 rounds, FINAL feed-forward, then hold.
module sha256_compress_iter
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  hash_t        H_in,
  input  block_t       W,
  output logic [0:255] H_out,
  output logic         done,
  output logic [31:0]  test
);

  typedef enum logic [1:0] {LOAD, ROUND, FINAL, DONE} state_t;

  state_t             state;
  state_t             state_d;
  logic [ROUND_W-1:0] t;
  hash_t              work;
  hash_t              h_save;
  block_t             window;
  hash_t              round_c;
  hash_t              final_c;
  word_t              new_w_c;

  sha256_compress_iter_round u_round (
    .cur    (work),
    .kt     (K[t]),
    .wt     (window[0]),
    .next_c (round_c)
  );

  always_comb begin
    new_w_c = small_sigma1(window[14]) + window[9] + small_sigma0(window[1]) + window[0];
    for (int i = 0; i < int'(HASH_N); i++) begin
      final_c[i] = h_save[i] + work[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LOAD;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      LOAD:    state_d = ROUND;
      ROUND:   if (t == ROUND_W'(ROUNDS - 1)) state_d = FINAL;
      FINAL:   state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = LOAD;
    endcase
  end

  // Datapath: inputs are sampled only in LOAD; result is latched once in FINAL.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      t      <= '0;
      work   <= '0;
      h_save <= '0;
      window <= '0;
      H_out  <= '0;
      done   <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          h_save <= H_in;
          work   <= H_in;
          window <= W;
          t      <= '0;
        end
        ROUND: begin
          work   <= round_c;
          window <= {window[1:BLOCK_N-1], new_w_c};
          t      <= t + ROUND_W'(1);
        end
        FINAL: begin
          H_out <= final_c;
          done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign test = work[0];

endmodule

// File: tb/tb_sha256_compress_iter.sv
// Directed bench for sha256_compress_iter using known SHA-256 single-block digests.
module tb_sha256_compress_iter;
  import sha256_pkg::*;

  logic         clk;
  logic         reset;
  hash_t        H_in;
  block_t       W;
  logic [0:255] H_out;
  logic         done;
  logic [31:0]  test;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [255:0] ABC_HASH =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY_HASH =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

  block_t abc_blk;
  block_t empty_blk;
  block_t blk3;

  sha256_compress_iter dut (
    .clk   (clk),
    .reset (reset),
    .H_in  (H_in),
    .W     (W),
    .H_out (H_out),
    .done  (done),
    .test  (test)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Release reset and count edges until done rises (0 if it never does).
  task automatic run_block(input hash_t h, input block_t w, input bit scramble,
                           output int rise, output logic [31:0] t_load, output logic [31:0] t_r0);
    H_in   = h;
    W      = w;
    rise   = 0;
    t_load = '0;
    t_r0   = '0;
    @(negedge clk);
    reset = 1'b1;
    for (int n = 1; n <= 80 && rise == 0; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        t_load = test;
        if (scramble) begin
          for (int i = 0; i < 8; i++)  H_in[i] = $urandom();
          for (int i = 0; i < 16; i++) W[i]    = $urandom();
        end
      end
      if (n == 2) t_r0 = test;
      if (done) rise = n;
    end
  endtask

  initial begin
    int          rise;
    logic [31:0] t_load;
    logic [31:0] t_r0;
    logic [0:255] held;

    abc_blk       = '0;
    abc_blk[0]    = 32'h61626380;
    abc_blk[15]   = 32'h00000018;
    empty_blk     = '0;
    empty_blk[0]  = 32'h80000000;
    blk3          = '0;
    blk3[0]       = 32'h87027980;
    blk3[15]      = 32'h00000018;

    H_in  = H0;
    W     = abc_blk;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_done",  256'(done),  256'(0));
    check("reset_h_out", 256'(H_out), 256'(0));
    check("reset_test",  256'(test),  256'(0));

    // "abc" with trace, hold and async reset from DONE
    run_block(H0, abc_blk, 1'b0, rise, t_load, t_r0);
    check("abc_latency", 256'(rise), 256'(66));
    check("abc_test_load", 256'(t_load), 256'(32'h6a09e667));
    check("abc_test_r0", 256'(t_r0), 256'(32'h5d6aebcd));
    check("abc_h_out", 256'(H_out), ABC_HASH);
    held = H_out;
    repeat (12) @(posedge clk);
    #1;
    check("abc_hold_h_out", 256'(H_out), 256'(held));
    check("abc_hold_done", 256'(done), 256'(1));
    #2 reset = 1'b0;
    #1;
    check("async_rst_done",  256'(done),  256'(0));
    check("async_rst_h_out", 256'(H_out), 256'(0));
    check("async_rst_test",  256'(test),  256'(0));
    apply_reset();

    // Empty message
    run_block(H0, empty_blk, 1'b0, rise, t_load, t_r0);
    check("empty_latency", 256'(rise), 256'(66));
    check("empty_h_out", 256'(H_out), EMPTY_HASH);
    apply_reset();

    // Third block: timing and completion only
    run_block(H0, blk3, 1'b0, rise, t_load, t_r0);
    check("blk3_latency", 256'(rise), 256'(66));
    check("blk3_done", 256'(done), 256'(1));
    check("blk3_test_load", 256'(t_load), 256'(32'h6a09e667));
    apply_reset();

    // Abort around round 30, then rerun "abc"
    H_in = H0;
    W    = empty_blk;
    @(negedge clk);
    reset = 1'b1;
    repeat (32) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("abort_test", 256'(test), 256'(0));
    check("abort_done", 256'(done), 256'(0));
    check("abort_h_out", 256'(H_out), 256'(0));
    apply_reset();
    run_block(H0, abc_blk, 1'b0, rise, t_load, t_r0);
    check("rerun_latency", 256'(rise), 256'(66));
    check("rerun_test_r0", 256'(t_r0), 256'(32'h5d6aebcd));
    check("rerun_h_out", 256'(H_out), ABC_HASH);
    apply_reset();

    // Inputs scrambled right after LOAD must not affect the result
    run_block(H0, abc_blk, 1'b1, rise, t_load, t_r0);
    check("scramble_latency", 256'(rise), 256'(66));
    check("scramble_h_out", 256'(H_out), ABC_HASH);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
